// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared widths, scheduler state encoding and fixed-point multiply
package gcn_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC   = 8;
  localparam int ROW_W  = 7;
  localparam int COL_W  = 5;
  localparam int NUM_W  = 1 << COL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Full-width signed product, arithmetic shift (floor), then wrap to DATA_W.
  function automatic logic [DATA_W-1:0] fx_mul(input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] shifted;
    prod    = a * b;
    shifted = prod >>> FRAC;
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/spmm_row_scheduler_if.sv
// rtl/spmm_row_scheduler_if.sv - weight load, nonzero stream and result slot signals
interface spmm_row_scheduler_if import gcn_pkg::*; ();

  logic              w_wr_en;
  logic              w_wr_sel;
  logic [COL_W-1:0]  w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              start;
  logic              nz_valid;
  logic              nz_ready;
  logic [ROW_W-1:0]  nz_row;
  logic [COL_W-1:0]  nz_col;
  logic [DATA_W-1:0] nz_data;
  logic              nz_last;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_row;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  w_wr_en, w_wr_sel, w_wr_addr, w_wr_data, start,
    input  nz_valid, nz_row, nz_col, nz_data, nz_last, out_ready,
    output nz_ready, out_valid, out_row, out_data0, out_data1, busy, done, err
  );

  modport master (
    output w_wr_en, w_wr_sel, w_wr_addr, w_wr_data, start,
    output nz_valid, nz_row, nz_col, nz_data, nz_last, out_ready,
    input  nz_ready, out_valid, out_row, out_data0, out_data1, busy, done, err
  );

endinterface

// File: rtl/spmm_mac_lane.sv
// rtl/spmm_mac_lane.sv - one weight column with its fixed-point multiply and row accumulator
module spmm_mac_lane import gcn_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [COL_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [COL_W-1:0]  i_col,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_load,
  input  logic              i_acc,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_w [NUM_W];
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_prod;

  assign w_prod = fx_mul(i_data, r_w[i_col]);
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_W; i++) r_w[i] <= '0;
      r_acc <= '0;
    end else begin
      if (i_wr_en) r_w[i_wr_addr] <= i_wr_data;
      if (i_load)     r_acc <= w_prod;
      else if (i_acc) r_acc <= r_acc + w_prod;
    end
  end

endmodule

// File: rtl/spmm_row_scheduler.sv
// rtl/spmm_row_scheduler.sv - sequences a row-sorted COO stream into per-row 2-column results
module spmm_row_scheduler import gcn_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  spmm_row_scheduler_if.slave  bus
);

  state_t            r_state;
  logic [ROW_W-1:0]  r_cur_row;
  logic              r_has_row;
  logic              r_out_valid;
  logic [ROW_W-1:0]  r_out_row;
  logic [DATA_W-1:0] r_out_d0;
  logic [DATA_W-1:0] r_out_d1;
  logic              r_done;
  logic              r_err;

  logic              w_slot_free;
  logic              w_nz_ready;
  logic              w_accept;
  logic              w_same;
  logic              w_row_change;
  logic              w_flush_go;
  logic              w_slot_load;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_acc0;
  logic [DATA_W-1:0] w_acc1;

  // No lookahead: a stalled slot blocks every entry, even ones for the current row.
  assign w_slot_free  = !r_out_valid || bus.out_ready;
  assign w_nz_ready   = (r_state == ST_RUN) && w_slot_free;
  assign w_accept     = bus.nz_valid && w_nz_ready;
  assign w_same       = r_has_row && (bus.nz_row == r_cur_row);
  assign w_row_change = w_accept && r_has_row && !w_same;
  assign w_flush_go   = (r_state == ST_FLUSH) && w_slot_free;
  assign w_slot_load  = w_row_change || (w_flush_go && r_has_row);
  assign w_wr_en      = bus.w_wr_en && (r_state == ST_IDLE);

  spmm_mac_lane u_lane0 (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en && !bus.w_wr_sel),
    .i_wr_addr (bus.w_wr_addr),
    .i_wr_data (bus.w_wr_data),
    .i_col     (bus.nz_col),
    .i_data    (bus.nz_data),
    .i_load    (w_accept && !w_same),
    .i_acc     (w_accept && w_same),
    .o_acc     (w_acc0)
  );

  spmm_mac_lane u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en && bus.w_wr_sel),
    .i_wr_addr (bus.w_wr_addr),
    .i_wr_data (bus.w_wr_data),
    .i_col     (bus.nz_col),
    .i_data    (bus.nz_data),
    .i_load    (w_accept && !w_same),
    .i_acc     (w_accept && w_same),
    .o_acc     (w_acc1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cur_row   <= '0;
      r_has_row   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_d0    <= '0;
      r_out_d1    <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_err   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (r_has_row && (bus.nz_row < r_cur_row)) r_err <= 1'b1;
            r_cur_row <= bus.nz_row;
            r_has_row <= 1'b1;
            if (bus.nz_last) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_slot_free) begin
            r_has_row <= 1'b0;
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A reload in the same cycle as a drain keeps the slot occupied.
      if (w_slot_load) begin
        r_out_valid <= 1'b1;
        r_out_row   <= r_cur_row;
        r_out_d0    <= w_acc0;
        r_out_d1    <= w_acc1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.nz_ready  = w_nz_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_row   = r_out_row;
  assign bus.out_data0 = r_out_d0;
  assign bus.out_data1 = r_out_d1;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_spmm_row_scheduler.sv
// tb/tb_spmm_row_scheduler.sv - directed self-checking bench for spmm_row_scheduler
module tb_spmm_row_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  int   n_done = 0;
  logic [38:0] res_q [$];

  spmm_row_scheduler_if bus_if ();

  spmm_row_scheduler dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Results and done pulses are observed mid-cycle, where everything is settled.
  always @(negedge clk) begin
    if (bus_if.out_valid && bus_if.out_ready)
      res_q.push_back({bus_if.out_row, bus_if.out_data0, bus_if.out_data1});
    if (bus_if.done) n_done++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input logic sel, input logic [4:0] addr, input logic [15:0] data);
    bus_if.w_wr_en   = 1'b1;
    bus_if.w_wr_sel  = sel;
    bus_if.w_wr_addr = addr;
    bus_if.w_wr_data = data;
    tick();
    bus_if.w_wr_en   = 1'b0;
  endtask

  task automatic do_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic send(input logic [6:0] r, input logic [4:0] c, input logic [15:0] d, input logic last);
    int n;
    n = 0;
    bus_if.nz_valid = 1'b1;
    bus_if.nz_row   = r;
    bus_if.nz_col   = c;
    bus_if.nz_data  = d;
    bus_if.nz_last  = last;
    while (!bus_if.nz_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus_if.nz_ready) chk("send_timeout", 32'd0, 32'd1);
    tick();
    bus_if.nz_valid = 1'b0;
    bus_if.nz_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [6:0] r, input logic [15:0] d0, input logic [15:0] d1);
    int n;
    logic [38:0] e;
    n = 0;
    while (res_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    if (res_q.size() == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      e = res_q.pop_front();
      chk({tag, "_row"}, 32'(e[38:32]), 32'(r));
      chk({tag, "_d0"},  32'(e[31:16]), 32'(d0));
      chk({tag, "_d1"},  32'(e[15:0]),  32'(d1));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus_if.busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(bus_if.busy), 32'd0);
    tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  32'(bus_if.busy), 32'd0);
    chk({tag, "_ovld"},  32'(bus_if.out_valid), 32'd0);
    chk({tag, "_rdy"},   32'(bus_if.nz_ready), 32'd0);
    chk({tag, "_done"},  32'(bus_if.done), 32'd0);
    chk({tag, "_err"},   32'(bus_if.err), 32'd0);
    chk({tag, "_row"},   32'(bus_if.out_row), 32'd0);
    chk({tag, "_d0"},    32'(bus_if.out_data0), 32'd0);
    chk({tag, "_d1"},    32'(bus_if.out_data1), 32'd0);
  endtask

  initial begin
    bus_if.w_wr_en = 1'b0; bus_if.w_wr_sel = 1'b0; bus_if.w_wr_addr = '0; bus_if.w_wr_data = '0;
    bus_if.start = 1'b0; bus_if.nz_valid = 1'b0; bus_if.nz_row = '0; bus_if.nz_col = '0;
    bus_if.nz_data = '0; bus_if.nz_last = 1'b0; bus_if.out_ready = 1'b1;
    tick();
    tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // 1: single entry, product check on both lanes and done timing
    wr_w(1'b0, 5'd3, 16'h0100);
    wr_w(1'b1, 5'd3, 16'h0080);
    do_start();
    chk("t1_busy_run", 32'(bus_if.busy), 32'd1);
    send(7'd5, 5'd3, 16'h0200, 1'b1);
    chk("t1_flush_ovld", 32'(bus_if.out_valid), 32'd0);
    chk("t1_flush_busy", 32'(bus_if.busy), 32'd1);
    tick();
    chk("t1_ovld", 32'(bus_if.out_valid), 32'd1);
    chk("t1_done", 32'(bus_if.done), 32'd1);
    chk("t1_idle", 32'(bus_if.busy), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(bus_if.done), 32'd0);
    expect_result("t1", 7'd5, 16'h0200, 16'h0100);

    // 2: accumulation within a row, then a row change and flush
    wr_w(1'b0, 5'd1, 16'h0100);
    wr_w(1'b0, 5'd2, 16'h0100);
    do_start();
    send(7'd2, 5'd1, 16'h0100, 1'b0);
    send(7'd2, 5'd2, 16'h0300, 1'b0);
    send(7'd7, 5'd1, 16'h0040, 1'b1);
    expect_result("t2a", 7'd2, 16'h0400, 16'h0000);
    expect_result("t2b", 7'd7, 16'h0040, 16'h0000);
    wait_idle();

    // 3: downstream stall holds the slot and blocks input
    bus_if.out_ready = 1'b0;
    do_start();
    send(7'd2, 5'd1, 16'h0100, 1'b0);
    send(7'd2, 5'd2, 16'h0300, 1'b0);
    send(7'd7, 5'd1, 16'h0040, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_rdy", 32'(bus_if.nz_ready), 32'd0);
      chk("t3_stall_ovld", 32'(bus_if.out_valid), 32'd1);
      chk("t3_stall_row", 32'(bus_if.out_row), 32'd2);
      chk("t3_stall_d0", 32'(bus_if.out_data0), 32'h0400);
      tick();
    end
    bus_if.out_ready = 1'b1;
    expect_result("t3a", 7'd2, 16'h0400, 16'h0000);
    expect_result("t3b", 7'd7, 16'h0040, 16'h0000);
    wait_idle();

    // 4: wrap-around accumulation, then floor of a negative product
    wr_w(1'b0, 5'd0, 16'h0100);
    do_start();
    send(7'd1, 5'd0, 16'h7F00, 1'b0);
    send(7'd1, 5'd0, 16'h0200, 1'b1);
    expect_result("t4_wrap", 7'd1, 16'h8100, 16'h0000);
    wait_idle();
    wr_w(1'b0, 5'd0, 16'hFF00);
    do_start();
    send(7'd1, 5'd0, 16'h0001, 1'b1);
    expect_result("t4_floor", 7'd1, 16'hFFFF, 16'h0000);
    wait_idle();

    // 5: row order violation raises err, both rows still emitted
    do_start();
    send(7'd9, 5'd3, 16'h0100, 1'b0);
    chk("t5_err_before", 32'(bus_if.err), 32'd0);
    send(7'd4, 5'd3, 16'h0100, 1'b1);
    chk("t5_err_set", 32'(bus_if.err), 32'd1);
    expect_result("t5a", 7'd9, 16'h0100, 16'h0080);
    expect_result("t5b", 7'd4, 16'h0100, 16'h0080);
    wait_idle();
    chk("t5_err_sticky", 32'(bus_if.err), 32'd1);
    do_start();
    chk("t5_err_clr", 32'(bus_if.err), 32'd0);
    send(7'd3, 5'd3, 16'h0100, 1'b1);
    expect_result("t5c", 7'd3, 16'h0100, 16'h0080);
    wait_idle();

    // 6: reset mid-pass clears everything including weights
    do_start();
    send(7'd9, 5'd3, 16'h0100, 1'b0);
    send(7'd4, 5'd3, 16'h0100, 1'b0);
    chk("t6_err_pre", 32'(bus_if.err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_rst");
    tick();
    res_q.delete();
    rst_n = 1'b1;
    tick();
    do_start();
    send(7'd5, 5'd3, 16'h0200, 1'b1);
    expect_result("t6_zero_w", 7'd5, 16'h0000, 16'h0000);
    wait_idle();

    chk("done_count", 32'(n_done), 32'd8);
    chk("no_extra_results", 32'(res_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
